// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port. The data port (D) wins
// contention unless it has already taken MAX_D_STREAK consecutive grants while
// the instruction port (I) was waiting, in which case I is forced through.
// The winner's request is captured at grant time and replayed on the memory
// port until pmem_resp, so requesters may change or drop their inputs
// mid-transaction without disturbing memory.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MAX_D_STREAK = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction port (read-only)
  input  logic                  read_i,
  input  logic [ADDR_W-1:0]     addr_i,
  output logic                  resp_i,
  output logic [DATA_W-1:0]     rdata_i,
  // data port (read/write)
  input  logic                  read_d,
  input  logic                  write_d,
  input  logic [ADDR_W-1:0]     addr_d,
  input  logic [DATA_W-1:0]     wdata_d,
  input  logic [DATA_W/8-1:0]   wmask_d,
  output logic                  resp_d,
  output logic [DATA_W-1:0]     rdata_d,
  // physical memory port
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_W-1:0]     pmem_address,
  output logic [DATA_W-1:0]     pmem_wdata,
  output logic [DATA_W/8-1:0]   pmem_wmask,
  input  logic [DATA_W-1:0]     pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int MASK_W = DATA_W / 8;
  localparam logic [2:0] STREAK_MAX = 3'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [MASK_W-1:0]   wmask_reg, wmask_next;
  logic                write_reg, write_next;
  logic [2:0]          d_streak_reg, d_streak_next;

  logic                d_pending;
  logic                d_may_win;

  assign d_pending = read_d | write_d;
  // D loses only when I is waiting and D has used up its streak allowance.
  assign d_may_win = d_pending && (!read_i || (d_streak_reg < STREAK_MAX));

  // State, request latches and streak counter; reset clears everything so all
  // outputs fall to zero immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wmask_reg    <= '0;
      write_reg    <= 1'b0;
      d_streak_reg <= 3'd0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      wmask_reg    <= wmask_next;
      write_reg    <= write_next;
      d_streak_reg <= d_streak_next;
    end
  end

  // Grant decision in IDLE and completion detection while serving.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    wmask_next    = wmask_reg;
    write_next    = write_reg;
    d_streak_next = d_streak_reg;
    case (state_reg)
      IDLE: begin
        if (d_may_win) begin
          state_next = SERVE_D;
          addr_next  = addr_d;
          wdata_next = wdata_d;
          wmask_next = wmask_d;
          write_next = write_d;
          // Only grants that make I wait count toward the streak.
          if (read_i) begin
            d_streak_next = (d_streak_reg < STREAK_MAX) ? d_streak_reg + 3'd1
                                                        : d_streak_reg;
          end else begin
            d_streak_next = 3'd0;
          end
        end else if (read_i) begin
          state_next    = SERVE_I;
          addr_next     = addr_i;
          wdata_next    = '0;
          wmask_next    = '0;
          write_next    = 1'b0;
          d_streak_next = 3'd0;
        end else begin
          d_streak_next = 3'd0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory port driven purely from the latched request; responses routed
  // to the owner only and data zeroed outside the response cycle.
  always_comb begin
    pmem_read    = (state_reg == SERVE_I) || ((state_reg == SERVE_D) && !write_reg);
    pmem_write   = (state_reg == SERVE_D) && write_reg;
    pmem_address = addr_reg;
    pmem_wdata   = wdata_reg;
    pmem_wmask   = wmask_reg;
    resp_i       = (state_reg == SERVE_I) && pmem_resp;
    resp_d       = (state_reg == SERVE_D) && pmem_resp;
    rdata_i      = resp_i ? pmem_rdata : '0;
    rdata_d      = resp_d ? pmem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. Two requester models and a memory
// model drive the DUT; a transaction-level reference tracks who owns the
// memory port and what request it carries, and every cycle's outputs are
// compared against it.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 16;
  localparam int MAX_D_STREAK = 2;
  localparam int MASK_W       = DATA_W / 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                read_i;
  logic [ADDR_W-1:0]   addr_i;
  logic                resp_i;
  logic [DATA_W-1:0]   rdata_i;
  logic                read_d;
  logic                write_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [MASK_W-1:0]   wmask_d;
  logic                resp_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                pmem_read;
  logic                pmem_write;
  logic [ADDR_W-1:0]   pmem_address;
  logic [DATA_W-1:0]   pmem_wdata;
  logic [MASK_W-1:0]   pmem_wmask;
  logic [DATA_W-1:0]   pmem_rdata;
  logic                pmem_resp;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .MAX_D_STREAK (MAX_D_STREAK)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read_i       (read_i),
    .addr_i       (addr_i),
    .resp_i       (resp_i),
    .rdata_i      (rdata_i),
    .read_d       (read_d),
    .write_d      (write_d),
    .addr_d       (addr_d),
    .wdata_d      (wdata_d),
    .wmask_d      (wmask_d),
    .resp_d       (resp_d),
    .rdata_d      (rdata_d),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_wmask   (pmem_wmask),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  int errors = 0;
  int checks = 0;
  int txn_count = 0;

  // reference model: who owns the port and the request captured at grant
  bit                m_busy;
  bit                m_owner_d;
  bit                m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [MASK_W-1:0] m_wmask;
  int                m_streak;
  int                mem_cnt;

  // requester models and knobs
  bit i_req, i_hold, i_done;
  bit d_req, d_write, d_done;
  int p_req;
  bit allow_flush;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pmem_read"},    32'(pmem_read),    32'd0);
    check({tag, ".pmem_write"},   32'(pmem_write),   32'd0);
    check({tag, ".pmem_address"}, 32'(pmem_address), 32'd0);
    check({tag, ".pmem_wdata"},   32'(pmem_wdata),   32'd0);
    check({tag, ".pmem_wmask"},   32'(pmem_wmask),   32'd0);
    check({tag, ".resp_i"},       32'(resp_i),       32'd0);
    check({tag, ".resp_d"},       32'(resp_d),       32'd0);
    check({tag, ".rdata_i"},      32'(rdata_i),      32'd0);
    check({tag, ".rdata_d"},      32'(rdata_d),      32'd0);
  endtask

  task automatic clear_model();
    m_busy = 0; m_owner_d = 0; m_write = 0;
    m_addr = '0; m_wdata = '0; m_wmask = '0;
    m_streak = 0; mem_cnt = 0;
    i_req = 0; i_hold = 0; i_done = 0;
    d_req = 0; d_write = 0; d_done = 0;
    read_i = 0; read_d = 0; write_d = 0;
  endtask

  // Drive requester and memory inputs for the current cycle.
  task automatic drive_inputs();
    pmem_rdata = DATA_W'($urandom);
    if (m_busy) pmem_resp = (mem_cnt == 1);
    else        pmem_resp = ($urandom_range(0, 15) == 0);

    if (i_done) begin i_req = 0; i_done = 0; end
    if (m_busy && !m_owner_d && i_req) begin
      if (allow_flush && $urandom_range(0, 24) == 0) begin
        i_req  = 0;
        i_hold = 1;
      end else if ($urandom_range(0, 1) == 1) begin
        addr_i = ADDR_W'($urandom);
      end
    end
    if (!i_req && !i_hold && $urandom_range(0, 99) < p_req) begin
      i_req  = 1;
      addr_i = ADDR_W'($urandom);
    end
    read_i = i_req;

    if (d_done) begin d_req = 0; d_done = 0; end
    if (m_busy && m_owner_d && d_req && $urandom_range(0, 1) == 1) begin
      addr_d  = ADDR_W'($urandom);
      wdata_d = DATA_W'($urandom);
      wmask_d = MASK_W'($urandom);
    end
    if (!d_req && $urandom_range(0, 99) < p_req) begin
      d_req   = 1;
      d_write = ($urandom_range(0, 1) == 1);
      addr_d  = ADDR_W'($urandom);
      wdata_d = DATA_W'($urandom);
      wmask_d = MASK_W'($urandom);
    end
    read_d  = d_req && !d_write;
    write_d = d_req && d_write;
  endtask

  // Compare this cycle's outputs with what the reference expects.
  task automatic check_outputs();
    bit exp_rd, exp_wr, exp_ri, exp_rd_d;
    exp_rd   = m_busy && (!m_owner_d || !m_write);
    exp_wr   = m_busy && m_owner_d && m_write;
    exp_ri   = m_busy && !m_owner_d && pmem_resp;
    exp_rd_d = m_busy && m_owner_d && pmem_resp;
    check("pmem_read",  32'(pmem_read),  32'(exp_rd));
    check("pmem_write", 32'(pmem_write), 32'(exp_wr));
    if (m_busy) check("pmem_address", 32'(pmem_address), 32'(m_addr));
    if (exp_wr) begin
      check("pmem_wdata", 32'(pmem_wdata), 32'(m_wdata));
      check("pmem_wmask", 32'(pmem_wmask), 32'(m_wmask));
    end
    check("resp_i",  32'(resp_i),  32'(exp_ri));
    check("resp_d",  32'(resp_d),  32'(exp_rd_d));
    check("rdata_i", 32'(rdata_i), exp_ri   ? 32'(pmem_rdata) : 32'd0);
    check("rdata_d", 32'(rdata_d), exp_rd_d ? 32'(pmem_rdata) : 32'd0);
  endtask

  // Advance the reference across the coming rising edge.
  task automatic update_model();
    if (m_busy) begin
      if (pmem_resp) begin
        txn_count++;
        $display("txn %0d: %s %s addr=%04h", txn_count, m_owner_d ? "D" : "I",
                 m_write ? "write" : "read ", m_addr);
        m_busy = 0;
        if (m_owner_d) d_done = 1;
        else begin i_done = 1; i_hold = 0; end
      end else begin
        mem_cnt--;
      end
    end else begin
      if (d_req && (!read_i || m_streak < MAX_D_STREAK)) begin
        m_busy = 1; m_owner_d = 1;
        m_addr = addr_d; m_write = d_write; m_wdata = wdata_d; m_wmask = wmask_d;
        m_streak = read_i ? ((m_streak + 1 > MAX_D_STREAK) ? MAX_D_STREAK : m_streak + 1) : 0;
      end else if (read_i) begin
        m_busy = 1; m_owner_d = 0; m_addr = addr_i; m_write = 0;
        m_streak = 0;
      end else begin
        m_streak = 0;
      end
      if (m_busy) mem_cnt = $urandom_range(2, 4);
    end
  endtask

  task automatic step();
    drive_inputs();
    #1;
    check_outputs();
    update_model();
    @(negedge clk);
  endtask

  // Pull reset while a transaction is on the port; strobes must vanish at once
  // and a trailing pmem_resp must produce nothing.
  task automatic reset_pulse();
    pmem_resp = 0;
    #1 check("pre_rst_strobe", 32'(pmem_read | pmem_write), 32'd1);
    #1 rst_n = 0;
    #1 check_all_zero("rst_async");
    pmem_resp  = 1;
    pmem_rdata = DATA_W'($urandom);
    #1 check_all_zero("rst_stray_resp");
    clear_model();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    bit found;
    rst_n = 1;
    addr_i = '0; addr_d = '0; wdata_d = '0; wmask_d = '0;
    pmem_rdata = '0; pmem_resp = 0;
    clear_model();
    p_req = 40;
    allow_flush = 1;

    #2 rst_n = 0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_held");
    rst_n = 1;

    // mixed traffic with flushes, address churn, stray responses, resets
    repeat (600) begin
      if (m_busy && $urandom_range(0, 79) == 0) reset_pulse();
      step();
    end

    // both requesters saturated: exercises the forced-fetch streak limit
    p_req = 100;
    allow_flush = 0;
    repeat (300) step();

    // reset landing on a D transaction
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_busy && m_owner_d) found = 1;
      else step();
    end
    check("find_serve_d", 32'(found), 32'd1);
    if (found) reset_pulse();

    p_req = 40;
    allow_flush = 1;
    repeat (100) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
